// File: rtl/memory_column_arbiter_pkg.sv
// Shared types and defaults for the memory column arbiter.
package memory_column_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mca_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_column_arbiter_if.sv
// Request/response and memory-side bus of the memory column arbiter.
interface memory_column_arbiter_if
    import memory_column_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_rdata_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic                      mem_en_o;
    logic [DATA_W-1:0]         mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_en_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_en_o
    );
endinterface

// File: rtl/memory_column_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    always_comb begin
        int   cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/memory_column_arbiter.sv
// Round-robin sharing of one memory_column between NUM_REQ requesters;
// one two-cycle transaction (grant, access) at a time.
module memory_column_arbiter
    import memory_column_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    memory_column_arbiter_if.slave  bus
);
    localparam int IDX_W = idx_w(NUM_REQ);

    mca_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                any_req;
    logic [NUM_REQ-1:0]  ready;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        ready       = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    ready   = gnt;
                    sel_d   = gnt_idx;
                    we_d    = bus.req_we_i[gnt_idx];
                    addr_d  = bus.req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata_i[gnt_idx*DATA_W +: DATA_W];
                    ptr_d   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Read data is sampled before the write lands, so writes return old contents.
                rsp_valid_d[sel_q] = 1'b1;
                rsp_rdata_d        = bus.mem_rdata_i;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready is gated by reset so held requests cannot show a grant while in reset.
    assign bus.req_ready_o = arst_ni ? ready : '0;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_en_o    = (state_q == ACCESS) && we_q;
endmodule

// File: tb/tb_memory_column_arbiter.sv
// Directed and random bench for memory_column_arbiter with a scoreboard and reference memory.
module tb_memory_column_arbiter;
    logic clk = 1'b0;
    logic arst_ni = 1'b0;
    always #5 clk = ~clk;

    memory_column_arbiter_if #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(8)) bus ();

    memory_column_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(8)) dut (
        .clk_i   (clk),
        .arst_ni (arst_ni),
        .bus     (bus)
    );

    // memory_column stand-in: sync write, async read
    logic [7:0] mem [1024] = '{default: 8'h00};
    always @(posedge clk) if (bus.mem_en_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    logic [1:0] v = '0, wr = '0;
    logic [9:0] a [2] = '{default: '0};
    logic [7:0] d [2] = '{default: '0};
    assign bus.req_valid_i = v;
    assign bus.req_we_i    = wr;
    assign bus.req_addr_i  = {a[1], a[0]};
    assign bus.req_wdata_i = {d[1], d[0]};

    typedef struct {
        int         idx;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        int         cyc;
    } txn_t;

    txn_t       sbq [$];
    int         gnt_log [$];
    logic [7:0] refm [1024] = '{default: 8'h00};
    int         total = 0, bad = 0, cyc = 0;
    logic       in_acc = 1'b0, acc_we = 1'b0;
    logic [9:0] acc_addr = '0;
    logic [7:0] last_rdata = '0;
    int         last_idx = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        txn_t t;
        cyc++;
        if (!arst_ni) begin
            sbq.delete();
            in_acc = 1'b0;
        end else begin
            chk("ready_onehot0", 32'($onehot0(bus.req_ready_o)), 1);
            if (in_acc) chk("ready_in_access", 32'(bus.req_ready_o), 0);
            chk("mem_en", 32'(bus.mem_en_o), 32'(in_acc && acc_we));
            if (in_acc) chk("mem_addr", 32'(bus.mem_addr_o), 32'(acc_addr));
            if (bus.rsp_valid_o != '0) begin
                if (sbq.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid_o), 0);
                else begin
                    t = sbq.pop_front();
                    chk("rsp_idx", 32'(bus.rsp_valid_o), 32'(1 << t.idx));
                    chk("rsp_data", 32'(bus.rsp_rdata_o), 32'(t.exp));
                    chk("rsp_latency", cyc, t.cyc + 2);
                    if (t.we) refm[t.addr] = t.wdata;
                    last_rdata = bus.rsp_rdata_o;
                    last_idx   = t.idx;
                end
            end
            in_acc = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
                    t.idx = k; t.we = wr[k]; t.addr = a[k]; t.wdata = d[k];
                    t.exp = refm[a[k]]; t.cyc = cyc;
                    sbq.push_back(t);
                    gnt_log.push_back(k);
                    in_acc = 1'b1; acc_we = wr[k]; acc_addr = a[k];
                end
            end
        end
    end

    task automatic do_req(input int k, input logic we_v, input logic [9:0] ad, input logic [7:0] wd);
        logic got;
        int   n;
        got = 1'b0;
        n   = 0;
        @(posedge clk); #1;
        wr[k] = we_v; a[k] = ad; d[k] = wd; v[k] = 1'b1;
        while (!got && n < 50) begin
            #1;
            if (bus.req_ready_o[k]) got = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        v[k] = 1'b0;
        chk("req_granted", 32'(got), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || in_acc) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 arst_ni = 1'b1;

        // 1: reset mid-run clears outputs and the rotation pointer
        do_req(0, 1'b1, 10'h001, 8'h3C);
        do_req(0, 1'b1, 10'h001, 8'h4D);
        wait_drain();
        chk("t1_old_data", 32'(last_rdata), 32'h3C);
        @(posedge clk); #3;
        wr[1] = 1'b0; a[1] = 10'h002; v[1] = 1'b1;
        arst_ni = 1'b0;
        #1;
        chk("t1_rst_ready", 32'(bus.req_ready_o), 0);
        chk("t1_rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("t1_rst_rdata", 32'(bus.rsp_rdata_o), 0);
        chk("t1_rst_mem_en", 32'(bus.mem_en_o), 0);
        chk("t1_rst_mem_addr", 32'(bus.mem_addr_o), 0);
        chk("t1_rst_mem_wdata", 32'(bus.mem_wdata_o), 0);
        repeat (2) @(posedge clk);
        #3 v[1] = 1'b0; arst_ni = 1'b1;
        gnt_log.delete();
        fork
            do_req(0, 1'b0, 10'h001, 8'h00);
            do_req(1, 1'b0, 10'h002, 8'h00);
        join
        wait_drain();
        chk("t1_grants", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            chk("t1_first_grant", gnt_log[0], 0);
            chk("t1_second_grant", gnt_log[1], 1);
        end

        // 2: single write then read at the top address
        do_req(0, 1'b1, 10'h3FF, 8'hA5);
        do_req(0, 1'b0, 10'h3FF, 8'h00);
        wait_drain();
        chk("t2_read_data", 32'(last_rdata), 32'hA5);
        chk("t2_read_idx", last_idx, 0);

        // 3: both requesters contending alternate strictly
        gnt_log.delete();
        fork
            for (int i = 0; i < 4; i++) do_req(0, 1'b0, 10'(10'h100 + i), 8'h00);
            for (int i = 0; i < 4; i++) do_req(1, 1'b1, 10'(10'h200 + i), 8'(8'h60 + i));
        join
        wait_drain();
        chk("t3_grants", gnt_log.size(), 8);
        for (int i = 1; i < gnt_log.size(); i++)
            chk("t3_alternate", gnt_log[i], 1 - gnt_log[i-1]);

        // 4: write returns the previous contents
        do_req(0, 1'b1, 10'h010, 8'h11);
        do_req(1, 1'b1, 10'h010, 8'h22);
        wait_drain();
        chk("t4_write_old", 32'(last_rdata), 32'h11);
        do_req(0, 1'b0, 10'h010, 8'h00);
        wait_drain();
        chk("t4_read_new", 32'(last_rdata), 32'h22);

        // 5: reset during ACCESS aborts the write
        do_req(0, 1'b1, 10'h005, 8'h55);
        wait_drain();
        do_req(0, 1'b1, 10'h005, 8'h77);
        #1 chk("t5_en_in_access", 32'(bus.mem_en_o), 1);
        arst_ni = 1'b0;
        #1;
        chk("t5_en_dropped", 32'(bus.mem_en_o), 0);
        chk("t5_no_rsp", 32'(bus.rsp_valid_o), 0);
        repeat (2) @(posedge clk);
        #3 arst_ni = 1'b1;
        do_req(0, 1'b0, 10'h005, 8'h00);
        wait_drain();
        chk("t5_prior_value", 32'(last_rdata), 32'h55);

        // 6: random traffic from both requesters against the reference memory
        fork
            for (int i = 0; i < 500; i++)
                do_req(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), 8'($urandom));
            for (int i = 0; i < 500; i++)
                do_req(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), 8'($urandom));
        join
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
